// File: rtl/alu_meta_pkg.sv
// ============================================================================
// Module      : alu_meta_pkg
// Description : Shared definitions for the metadata-modify pipeline: opcode
//               values, metadata field positions, action word field positions,
//               the decoded action record and a small opcode helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_meta_pkg;

  // Opcodes that rewrite metadata (all share the 2'b11 prefix)
  localparam logic [3:0] OP_PORT         = 4'b1100;
  localparam logic [3:0] OP_DISCARD      = 4'b1101;
  localparam logic [3:0] OP_MCAST        = 4'b1110;
  localparam logic [3:0] OP_PORT_DISCARD = 4'b1111;

  // Metadata field positions
  localparam int DST_PORT_LSB = 24;   // meta[31:24]
  localparam int DISCARD_BIT  = 128;  // meta[128]
  localparam int NTID_LSB     = 250;  // meta[255:250]

  // Action word field positions
  localparam int ACT_OP_LSB      = 21;  // action[24:21]
  localparam int ACT_DST_LSB     = 13;  // action[20:13]
  localparam int ACT_DISCARD_BIT = 12;  // action[12]
  localparam int ACT_NTID_LSB    = 5;   // action[10:5]

  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] dst_port;
    logic       discard;
    logic [5:0] ntid;
  } action_t;

  // True for the four opcodes that modify metadata (and stamp next_table_id)
  function automatic logic is_modify_op(input logic [3:0] opcode);
    return (opcode[3:2] == 2'b11);
  endfunction

endpackage : alu_meta_pkg

`default_nettype wire

// File: rtl/alu_meta_modify.sv
// ============================================================================
// Module      : alu_meta_modify
// Description : Purely combinational metadata rewrite applied in stage 1.
//               Decodes the action word and patches dst_port, discard flag and
//               next_table_id fields of the metadata.
// Ports       : meta_in   [META_LEN]   metadata before modification
//               action_in [ACTION_LEN] action word
//               meta_out  [META_LEN]   metadata after modification
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_meta_modify
  import alu_meta_pkg::*;
#(
  parameter int META_LEN   = 256,
  parameter int ACTION_LEN = 25
) (
  input  logic [META_LEN-1:0]   meta_in,
  input  logic [ACTION_LEN-1:0] action_in,
  output logic [META_LEN-1:0]   meta_out
);

  action_t act;

  assign act.opcode   = action_in[ACT_OP_LSB +: 4];
  assign act.dst_port = action_in[ACT_DST_LSB +: 8];
  assign act.discard  = action_in[ACT_DISCARD_BIT];
  assign act.ntid     = action_in[ACT_NTID_LSB +: 6];

  // Reserved action bits ([11], [4:0], anything above [24]) are ignored
  logic unused_action;
  assign unused_action = &{1'b0, action_in};

  always_comb begin
    meta_out = meta_in;
    if (is_modify_op(act.opcode)) begin
      meta_out[NTID_LSB +: 6] = act.ntid;
    end
    case (act.opcode)
      OP_PORT: begin
        meta_out[DST_PORT_LSB +: 8] = act.dst_port;
      end
      OP_DISCARD: begin
        meta_out[DISCARD_BIT] = act.discard;
      end
      OP_MCAST: begin
        meta_out[DST_PORT_LSB +: 8] = meta_in[DST_PORT_LSB +: 8] | act.dst_port;
      end
      OP_PORT_DISCARD: begin
        meta_out[DST_PORT_LSB +: 8] = act.dst_port;
        meta_out[DISCARD_BIT]       = act.discard;
      end
      default: begin
        // pass-through
      end
    endcase
  end

endmodule : alu_meta_modify

`default_nettype wire

// File: rtl/alu_meta_pipe.sv
// ============================================================================
// Module      : alu_meta_pipe
// Description : LATENCY-deep metadata modification pipeline. Stage 1 applies
//               the action to the metadata; later stages only delay it. The
//               whole pipe freezes while the output is valid and not taken.
// Ports       : clk, rst                      clock / sync active-high reset
//               comp_meta_data_in/_valid_in   metadata input
//               action_in/action_valid_in     action input (paired w/ meta)
//               in_ready                      pair accepted when both valid
//               comp_meta_data_out/_valid_out modified metadata output
//               out_ready                     downstream accept
//               pkt_cnt, drop_cnt             statistics (ALU_META_STATS_EN)
// Config      : `define ALU_META_STATS_EN to add the statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_meta_pipe
  import alu_meta_pkg::*;
#(
  parameter int META_LEN   = 256,
  parameter int ACTION_LEN = 25,
  parameter int LATENCY    = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [META_LEN-1:0]   comp_meta_data_in,
  input  logic                  comp_meta_data_valid_in,
  input  logic [ACTION_LEN-1:0] action_in,
  input  logic                  action_valid_in,
  output logic                  in_ready,
  output logic [META_LEN-1:0]   comp_meta_data_out,
  output logic                  comp_meta_data_valid_out,
  input  logic                  out_ready
`ifdef ALU_META_STATS_EN
  ,
  output logic [CNT_W-1:0]      pkt_cnt,
  output logic [CNT_W-1:0]      drop_cnt
`endif
);

  generate
    if (META_LEN < 256 || ACTION_LEN < 25 || LATENCY < 1 || LATENCY > 16 || CNT_W < 1)
    begin : g_bad_params
      $error("alu_meta_pipe: illegal parameter value");
    end
  endgenerate

  logic [META_LEN-1:0] stage_data_q [LATENCY];
  logic [META_LEN-1:0] stage_data_d [LATENCY];
  logic [LATENCY-1:0]  stage_valid_q;
  logic [LATENCY-1:0]  stage_valid_d;

  logic [META_LEN-1:0] modified_meta;
  logic                stall;
  logic                accept;

  alu_meta_modify #(
    .META_LEN   (META_LEN),
    .ACTION_LEN (ACTION_LEN)
  ) u_modify (
    .meta_in   (comp_meta_data_in),
    .action_in (action_in),
    .meta_out  (modified_meta)
  );

  // Stalls freeze every stage, so bubbles travel with the data
  assign stall    = stage_valid_q[LATENCY-1] && !out_ready;
  assign in_ready = !stall && !rst;
  assign accept   = comp_meta_data_valid_in && action_valid_in && in_ready;

  always_comb begin
    stage_valid_d = stage_valid_q;
    for (int k = 0; k < LATENCY; k++) begin
      stage_data_d[k] = stage_data_q[k];
    end
    if (!stall) begin
      stage_valid_d[0] = accept;
      stage_data_d[0]  = modified_meta;
      for (int k = 1; k < LATENCY; k++) begin
        stage_valid_d[k] = stage_valid_q[k-1];
        stage_data_d[k]  = stage_data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        stage_data_q[k] <= '0;
      end
    end else begin
      stage_valid_q <= stage_valid_d;
      for (int k = 0; k < LATENCY; k++) begin
        stage_data_q[k] <= stage_data_d[k];
      end
    end
  end

  assign comp_meta_data_out       = stage_data_q[LATENCY-1];
  assign comp_meta_data_valid_out = stage_valid_q[LATENCY-1];

`ifdef ALU_META_STATS_EN
  logic [CNT_W-1:0] pkt_cnt_q;
  logic [CNT_W-1:0] pkt_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q;
  logic [CNT_W-1:0] drop_cnt_d;
  logic             drop_evt;

  // A drop is counted when a discard-flagged output is actually handed off
  assign drop_evt = comp_meta_data_valid_out && out_ready && comp_meta_data_out[DISCARD_BIT];

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (accept) begin
      pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
    end
    if (drop_evt) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule : alu_meta_pipe

`default_nettype wire

// File: tb/tb_alu_meta_pipe.sv
// ============================================================================
// Module      : tb_alu_meta_pipe
// Description : Self-checking bench for alu_meta_pipe: directed vector table,
//               stall / reset / half-valid sequences, and randomized traffic
//               against a queue-based reference model.
// Config      : ALU_META_STATS_EN also exercises the statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_meta_pipe;

  localparam int ML  = 256;
  localparam int AL  = 25;
  localparam int LAT = 4;
`ifdef ALU_META_STATS_EN
  localparam int CW  = 4;
`else
  localparam int CW  = 32;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [ML-1:0] meta_in;
  logic          mvalid;
  logic [AL-1:0] action;
  logic          avalid;
  logic          in_ready;
  logic [ML-1:0] meta_out;
  logic          vout;
  logic          out_ready;
`ifdef ALU_META_STATS_EN
  logic [CW-1:0] pkt_cnt;
  logic [CW-1:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  alu_meta_pipe #(
    .META_LEN   (ML),
    .ACTION_LEN (AL),
    .LATENCY    (LAT),
    .CNT_W      (CW)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .comp_meta_data_in        (meta_in),
    .comp_meta_data_valid_in  (mvalid),
    .action_in                (action),
    .action_valid_in          (avalid),
    .in_ready                 (in_ready),
    .comp_meta_data_out       (meta_out),
    .comp_meta_data_valid_out (vout),
    .out_ready                (out_ready)
`ifdef ALU_META_STATS_EN
    ,
    .pkt_cnt                  (pkt_cnt),
    .drop_cnt                 (drop_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [ML-1:0] exp_q [$];
  logic [ML-1:0] got_q [$];
  int            got_cyc [$];
  logic [CW-1:0] pkt_model  = '0;
  logic [CW-1:0] drop_model = '0;
  logic          prev_stall = 1'b0;
  logic [ML-1:0] prev_out   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [ML-1:0] act, input logic [ML-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference: the rewrite rules stated as plain field arithmetic
  function automatic logic [ML-1:0] ref_model(input logic [ML-1:0] m, input logic [AL-1:0] a);
    logic [ML-1:0] r;
    int op, dst, disc, nt;
    op   = int'(a[24:21]);
    dst  = int'(a[20:13]);
    disc = int'(a[12]);
    nt   = int'(a[10:5]);
    r = m;
    if (op >= 12) begin
      r[255:250] = 6'(nt);
      if (op == 12 || op == 15) r[31:24] = 8'(dst);
      if (op == 14)             r[31:24] = m[31:24] | 8'(dst);
      if (op == 13 || op == 15) r[128]   = disc[0];
    end
    return r;
  endfunction

  function automatic logic [AL-1:0] mk_act(input logic [3:0] op, input logic [7:0] dst,
                                           input logic disc, input logic [5:0] nt,
                                           input logic [5:0] junk);
    return {op, dst, disc, junk[5], nt, junk[4:0]};
  endfunction

  function automatic logic [ML-1:0] rand_meta();
    logic [ML-1:0] m;
    for (int i = 0; i < ML / 32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [AL-1:0] rand_act();
    logic [3:0] op;
    op = ($urandom_range(0, 2) != 0) ? {2'b11, 2'($urandom_range(0, 3))} : 4'($urandom);
    return mk_act(op, 8'($urandom), 1'($urandom), 6'($urandom), 6'($urandom));
  endfunction

  // Monitor: decides handshakes exactly as the DUT sees them at the next edge
  always @(negedge clk) begin
    if (rst) begin
      check("in_ready_during_rst", ML'(in_ready), ML'(0));
      exp_q.delete();
      pkt_model  = '0;
      drop_model = '0;
      prev_stall <= 1'b0;
    end else begin
      check("in_ready_rule", ML'(in_ready), ML'(!(vout && !out_ready)));
      if (prev_stall) begin
        check("stall_hold_valid", ML'(vout), ML'(1));
        check("stall_hold_data", meta_out, prev_out);
      end
      if (mvalid && avalid && in_ready) begin
        exp_q.push_back(ref_model(meta_in, action));
        pkt_model = pkt_model + 1'b1;
      end
      if (vout && out_ready) begin
        got_q.push_back(meta_out);
        got_cyc.push_back(cyc);
        if (meta_out[128]) drop_model = drop_model + 1'b1;
        check("output_expected", ML'(exp_q.size() != 0), ML'(1));
        if (exp_q.size() != 0) check("scoreboard", meta_out, exp_q.pop_front());
      end
      prev_stall <= vout && !out_ready;
      prev_out   <= meta_out;
    end
  end

  task automatic send(input logic [ML-1:0] m, input logic [AL-1:0] a);
    int t;
    meta_in = m;
    action  = a;
    mvalid  = 1'b1;
    avalid  = 1'b1;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("send_timeout", ML'(t < 200), ML'(1));
    @(posedge clk);
    #1;
    mvalid = 1'b0;
    avalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_got(input int n);
    for (int t = 0; t < 100 && got_q.size() < n; t++) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [ML-1:0] meta;
    logic [AL-1:0] act;
    logic [ML-1:0] exp;
  } vec_t;

  vec_t vecs [8];

`ifdef ALU_META_STATS_EN
  logic [CW-1:0] pkt_snap;
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Directed vector table: expectations worked out by hand
    vecs[0] = '{ML'(0), mk_act(4'b1100, 8'h05, 1'b0, 6'd3, 6'h00),
                (ML'(8'h05) << 24) | (ML'(3) << 250)};
    vecs[1] = '{ML'(0), mk_act(4'b1101, 8'hAA, 1'b1, 6'd7, 6'h3F),
                (ML'(1) << 128) | (ML'(7) << 250)};
    vecs[2] = '{ML'(8'h0A) << 24, mk_act(4'b1110, 8'h05, 1'b1, 6'd1, 6'h00),
                (ML'(8'h0F) << 24) | (ML'(1) << 250)};
    vecs[3] = '{{ML{1'b1}}, mk_act(4'b1111, 8'h00, 1'b0, 6'd0, 6'h15),
                ~((ML'(8'hFF) << 24) | (ML'(1) << 128) | (ML'(6'h3F) << 250))};
    vecs[4] = '{{8{32'hDEADBEEF}}, mk_act(4'b0000, 8'hFF, 1'b1, 6'h3F, 6'h00),
                {8{32'hDEADBEEF}}};
    vecs[5] = '{(ML'(1) << 128) | (ML'(8'hAB) << 24), mk_act(4'b1101, 8'h00, 1'b0, 6'h2A, 6'h00),
                (ML'(8'hAB) << 24) | (ML'(6'h2A) << 250)};
    vecs[6] = '{ML'(1) | (ML'(6'h15) << 250), mk_act(4'b1011, 8'h77, 1'b1, 6'h3F, 6'h00),
                ML'(1) | (ML'(6'h15) << 250)};
    vecs[7] = '{(ML'(8'hF0) << 24) | (ML'(6'h3F) << 250), mk_act(4'b1110, 8'h0F, 1'b0, 6'h00, 6'h00),
                ML'(8'hFF) << 24};

    rst = 1'b1; meta_in = '0; action = '0; out_ready = 1'b1;
    // A pair offered during reset must be ignored
    mvalid = 1'b1; avalid = 1'b1;
    idle(3);
    check("rst_valid_out", ML'(vout), ML'(0));
    check("rst_data_out", meta_out, ML'(0));
`ifdef ALU_META_STATS_EN
    check("rst_pkt_cnt", ML'(pkt_cnt), ML'(0));
    check("rst_drop_cnt", ML'(drop_cnt), ML'(0));
`endif
    rst = 1'b0; mvalid = 1'b0; avalid = 1'b0;
    idle(LAT + 2);
    check("no_output_from_rst_pair", ML'(got_q.size()), ML'(0));

    // Single pair: exact latency
    begin
      int early;
      early = 0;
      send(vecs[0].meta, vecs[0].act);
      for (int k = 1; k <= LAT; k++) begin
        if (k > 1) begin @(posedge clk); #1; end
        if (k < LAT && vout) early++;
      end
      check("latency_no_early_valid", ML'(early), ML'(0));
      check("latency_valid_at_LAT", ML'(vout), ML'(1));
      check("latency_data", meta_out, vecs[0].exp);
    end
    idle(3);

    // Back-to-back vector table
    got_q.delete(); got_cyc.delete();
    for (int i = 0; i < 8; i++) send(vecs[i].meta, vecs[i].act);
    wait_got(8);
    check("b2b_count", ML'(got_q.size()), ML'(8));
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      check($sformatf("vec%0d_out", i), got_q[i], vecs[i].exp);
    if (got_cyc.size() >= 8)
      check("b2b_consecutive", ML'(got_cyc[7] - got_cyc[0]), ML'(7));

    // Stall with a full pipe
    got_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < LAT; i++) send(rand_meta(), rand_act());
    meta_in = rand_meta(); action = rand_act(); mvalid = 1'b1; avalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", ML'(in_ready), ML'(0));
      check("stall_vout", ML'(vout), ML'(1));
    end
    check("stall_no_output", ML'(got_q.size()), ML'(0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    mvalid = 1'b0; avalid = 1'b0;
    wait_got(LAT + 1);
    idle(LAT + 3);
    check("stall_release_count", ML'(got_q.size()), ML'(LAT + 1));
    check("stall_scoreboard_empty", ML'(exp_q.size()), ML'(0));

    // Half-valid inputs are ignored
    got_q.delete();
`ifdef ALU_META_STATS_EN
    pkt_snap = pkt_cnt;
`endif
    meta_in = rand_meta(); action = rand_act();
    avalid = 1'b1; mvalid = 1'b0; idle(4);
    avalid = 1'b0; mvalid = 1'b1; idle(4);
    mvalid = 1'b0;
    idle(LAT + 4);
    check("half_valid_no_output", ML'(got_q.size()), ML'(0));
`ifdef ALU_META_STATS_EN
    check("half_valid_pkt_cnt", ML'(pkt_cnt), ML'(pkt_snap));
`endif

    // Reset with pairs in flight
    got_q.delete();
    for (int i = 0; i < 3; i++) send(rand_meta(), mk_act(4'b1101, 8'h1, 1'b1, 6'd2, 6'd0));
    do_reset();
    check("flush_vout", ML'(vout), ML'(0));
    check("flush_data", meta_out, ML'(0));
`ifdef ALU_META_STATS_EN
    check("flush_pkt_cnt", ML'(pkt_cnt), ML'(0));
    check("flush_drop_cnt", ML'(drop_cnt), ML'(0));
`endif
    idle(LAT + 5);
    check("flush_no_output", ML'(got_q.size()), ML'(0));

    // Randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      mvalid    = ($urandom_range(0, 3) != 0);
      avalid    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      meta_in   = rand_meta();
      action    = rand_act();
      @(posedge clk); #1;
    end
    mvalid = 1'b0; avalid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
    idle(2);
    check("random_drained", ML'(exp_q.size()), ML'(0));
`ifdef ALU_META_STATS_EN
    check("random_pkt_cnt", ML'(pkt_cnt), ML'(pkt_model));
    check("random_drop_cnt", ML'(drop_cnt), ML'(drop_model));

    // 17 pairs, 2 discards, 4-bit counters
    do_reset();
    for (int i = 0; i < 17; i++)
      send(ML'(0), (i == 3 || i == 9) ? mk_act(4'b1101, 8'h0, 1'b1, 6'd1, 6'd0)
                                      : mk_act(4'b1111, 8'h3, 1'b0, 6'd1, 6'd0));
    idle(LAT + 4);
    check("wrap_pkt_cnt", ML'(pkt_cnt), ML'(1));
    check("wrap_drop_cnt", ML'(drop_cnt), ML'(2));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_alu_meta_pipe

`default_nettype wire

// File: doc/alu_meta_pipe.md
ALU_META_PIPE -- requirements
Module: alu_meta_pipe

Interface
REQ-001 SHALL have parameter META_LEN, default 256, metadata width (SHALL be >= 256).
REQ-002 SHALL have parameter ACTION_LEN, default 25, action word width (SHALL be >= 25).
REQ-003 SHALL have parameter LATENCY, default 4, input-to-output pipeline depth in cycles (SHALL be 1..16).
REQ-004 SHALL have parameter CNT_W, default 32, statistics counter width.
REQ-005 clk  input  1  sole clock, all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 comp_meta_data_in  input  META_LEN  metadata of current packet.
REQ-008 comp_meta_data_valid_in  input  1  metadata valid.
REQ-009 action_in  input  ACTION_LEN  action word, paired with metadata in same cycle.
REQ-010 action_valid_in  input  1  action valid.
REQ-011 in_ready  output  1  pipeline can accept a pair this cycle.
REQ-012 comp_meta_data_out  output  META_LEN  modified metadata.
REQ-013 comp_meta_data_valid_out  output  1  output valid.
REQ-014 out_ready  input  1  downstream accepts output this cycle.
REQ-015 pkt_cnt  output  CNT_W  accepted-pair count (only with ALU_META_STATS_EN).
REQ-016 drop_cnt  output  CNT_W  outputs emitted with discard bit set (only with ALU_META_STATS_EN).

Function
REQ-017 A pair SHALL be accepted when comp_meta_data_valid_in && action_valid_in && in_ready; either valid alone SHALL be ignored (no output, no state change).
REQ-018 Opcode SHALL be action_in[24:21]; dst_port field action_in[20:13]; discard flag action_in[12]; next_table_id action_in[10:5].
REQ-019 Opcode 4'b1100: meta[31:24] := dst_port, other bits unchanged except REQ-023.
REQ-020 Opcode 4'b1101: meta[128] := discard flag, other bits unchanged except REQ-023.
REQ-021 Opcode 4'b1110 (multicast add): meta[31:24] := meta[31:24] | dst_port.
REQ-022 Opcode 4'b1111: meta[31:24] := dst_port and meta[128] := discard flag.
REQ-023 For opcodes 1100..1111, meta[255:250] := next_table_id; bits [META_LEN-1:256] always pass unchanged.
REQ-024 Any other opcode SHALL pass metadata unmodified, including [255:250].
REQ-025 Modification SHALL be computed in stage 1; stages 2..LATENCY SHALL delay data+valid; an accepted pair SHALL appear on outputs exactly LATENCY cycles later when no stall occurs.
REQ-026 Pipeline SHALL accept one pair per cycle back-to-back (full throughput, no idle states).
REQ-027 Stall = comp_meta_data_valid_out && !out_ready; during stall all stages SHALL hold and in_ready SHALL be 0.
REQ-028 in_ready SHALL equal !stall (combinational); bubbles SHALL NOT be compressed.
REQ-029 Output data SHALL be held stable while valid and not accepted; data with valid low is don't-care.
REQ-030 Simultaneous accept and output handshake SHALL both complete in the same cycle.

Reset
REQ-031 On rst all stage valids, comp_meta_data_valid_out, comp_meta_data_out, pkt_cnt, drop_cnt SHALL be 0 at next edge; in-flight pairs SHALL be discarded.
REQ-032 A pair presented during rst SHALL NOT be accepted; in_ready SHALL be 0 while rst high.

Configuration
REQ-033 Macro ALU_META_STATS_EN: defined -> pkt_cnt increments per accepted pair, drop_cnt per output handshake with meta[128]=1, both wrap at 2^CNT_W-1 -> 0; undefined -> ports and counters absent.

Structure
REQ-034 Package alu_meta_pkg SHALL hold opcode constants (OP_PORT, OP_DISCARD, OP_MCAST, OP_PORT_DISCARD) and field bit positions (DST_PORT_LSB=24, DISCARD_BIT=128, NTID_LSB=250).
REQ-035 Stage 1 modify logic SHALL live in sub-module alu_meta_modify (combinational); delay stages in the top.

Verification
REQ-036 Reset, then pair op=1100 dst=0x05 ntid=3, meta=0 -> after LATENCY cycles out[31:24]=0x05, out[255:250]=3, others 0.
REQ-037 Back-to-back 8 pairs ops 1100/1101/1110/1111/0000, out_ready=1 -> 8 consecutive outputs in order, each matching REQ-019..024 (1110 with meta[31:24]=0x0A, dst=0x05 -> 0x0F).
REQ-038 out_ready=0 for 5 cycles with pipeline full -> in_ready=0, output held stable, no loss/duplication after release.
REQ-039 action_valid_in=1 with comp_meta_data_valid_in=0 -> no output, pkt_cnt unchanged.
REQ-040 rst asserted with 3 pairs in flight -> no outputs afterwards, counters 0.
REQ-041 With ALU_META_STATS_EN, CNT_W=4: 17 pairs, 2 with discard=1 -> pkt_cnt=1 (wrapped), drop_cnt=2.
